// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives one full-adder slice LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] resShift_q, resShift_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             bInvert;

  logic sliceA, sliceB, sliceY, sliceS, sliceC;
  logic lastBit;

`ifdef SERIAL_ADDER_SUB_EN
  logic subMode_q, subMode_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      subMode_q <= 1'b0;
    end else begin
      subMode_q <= subMode_d;
    end
  end

  always_comb begin
    subMode_d = subMode_q;
    if (state_q == IDLE && start) begin
      subMode_d = sub;
    end
  end

  assign bInvert = subMode_q;
`else
  assign bInvert = 1'b0;
`endif

  // The shared full-adder slice; B is inverted in subtract mode.
  assign sliceA  = aShift_q[0];
  assign sliceB  = bShift_q[0] ^ bInvert;
  assign sliceY  = carry_q;
  assign sliceS  = sliceA ^ sliceB ^ sliceY;
  assign sliceC  = (sliceA & sliceB) | (sliceA & sliceY) | (sliceB & sliceY);
  assign lastBit = (count_q == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aShift_q   <= '0;
      bShift_q   <= '0;
      resShift_q <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      resShift_q <= resShift_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
    end
  end

  // Result bits enter at the MSB so that after WIDTH shifts the first bit sits at bit 0.
  always_comb begin
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    resShift_d = resShift_q;
    carry_d    = carry_q;
    count_d    = count_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aShift_d = a_in;
          bShift_d = b_in;
          count_d  = '0;
`ifdef SERIAL_ADDER_SUB_EN
          carry_d  = sub ? 1'b1 : cin;
`else
          carry_d  = cin;
`endif
        end
      end
      RUN: begin
        resShift_d = {sliceS, resShift_q[WIDTH-1:1]};
        aShift_d   = {1'b0, aShift_q[WIDTH-1:1]};
        bShift_d   = {1'b0, bShift_q[WIDTH-1:1]};
        carry_d    = sliceC;
        count_d    = count_q + CW'(1);
        if (lastBit) begin
          sum_d  = {sliceS, resShift_q[WIDTH-1:1]};
          cout_d = sliceC;
        end
      end
      default: ;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
